// File: rtl/div_pkg.sv
// Shared constants and state encoding for the restoring divider controller.
package div_pkg;

   localparam int unsigned DIV_W    = 16;
   localparam int unsigned DIV_ITER = 16;
   localparam int unsigned CNT_W    = $clog2(DIV_ITER);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } div_state_t;

endpackage

// File: rtl/div_sub.sv
// 16-bit unsigned subtractor, result modulo 2^16.
module div_sub
   import div_pkg::*;
(
   input  logic [DIV_W-1:0] rs1,
   input  logic [DIV_W-1:0] rs2,
   output logic [DIV_W-1:0] rd
);

   assign rd = rs1 - rs2;

endmodule

// File: rtl/div_ctrl.sv
// Sequential 16-bit unsigned restoring divider, one quotient bit per RUN cycle.
// Optional build macro DIV_ZERO_FAST_EN: a zero divisor skips RUN and finishes in one edge.
module div_ctrl
   import div_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_valid,
   output logic             start_ready,
   input  logic [DIV_W-1:0] dividend,
   input  logic [DIV_W-1:0] divisor,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [DIV_W-1:0] quotient,
   output logic [DIV_W-1:0] remainder,
   output logic             div_by_zero,
   output logic             busy
);

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIV_ITER - 1);

   div_state_t       state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [DIV_W-1:0] dvd_q;
   logic [DIV_W-1:0] dvs_q;
   // Partial remainder R; its 17th bit is always zero between steps, so only Rs carries it.
   logic [DIV_W-1:0] rem_q;
   logic [DIV_W-1:0] q_acc_q;
   logic [DIV_W-1:0] quotient_q;
   logic [DIV_W-1:0] remainder_q;
   logic             dbz_q;
   logic             res_valid_q;
   logic             start_ready_q;
   logic             busy_q;

   logic [CNT_W-1:0] bit_idx_c;
   logic [DIV_W:0]   rs_c;
   logic             ge_c;
   logic [DIV_W-1:0] diff_c;
   logic [DIV_W-1:0] rem_step_c;
   logic [DIV_W-1:0] q_step_c;

   div_sub u_sub (
      .rs1 (rs_c[DIV_W-1:0]),
      .rs2 (dvs_q),
      .rd  (diff_c)
   );

   // One restoring step: shift in the next dividend bit, subtract if it fits.
   always_comb begin
      bit_idx_c            = LAST_CNT - cnt_q;
      rs_c                 = {rem_q, dvd_q[bit_idx_c]};
      ge_c                 = (rs_c >= {1'b0, dvs_q});
      rem_step_c           = ge_c ? diff_c : rs_c[DIV_W-1:0];
      q_step_c             = q_acc_q;
      q_step_c[bit_idx_c]  = ge_c;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         dvd_q         <= '0;
         dvs_q         <= '0;
         rem_q         <= '0;
         q_acc_q       <= '0;
         quotient_q    <= '0;
         remainder_q   <= '0;
         dbz_q         <= 1'b0;
         res_valid_q   <= 1'b0;
         start_ready_q <= 1'b1;
         busy_q        <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start_valid) begin
                  dvd_q         <= dividend;
                  dvs_q         <= divisor;
                  rem_q         <= '0;
                  q_acc_q       <= '0;
                  cnt_q         <= '0;
                  dbz_q         <= (divisor == '0);
                  start_ready_q <= 1'b0;
                  busy_q        <= 1'b1;
`ifdef DIV_ZERO_FAST_EN
                  if (divisor == '0) begin
                     state_q     <= DONE;
                     quotient_q  <= '1;
                     remainder_q <= dividend;
                     res_valid_q <= 1'b1;
                  end else begin
                     state_q     <= RUN;
                  end
`else
                  state_q       <= RUN;
`endif
               end
            end
            RUN: begin
               rem_q   <= rem_step_c;
               q_acc_q <= q_step_c;
               if (cnt_q == LAST_CNT) begin
                  state_q     <= DONE;
                  quotient_q  <= q_step_c;
                  remainder_q <= rem_step_c;
                  res_valid_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            DONE: begin
               if (res_ready) begin
                  state_q       <= IDLE;
                  res_valid_q   <= 1'b0;
                  start_ready_q <= 1'b1;
                  busy_q        <= 1'b0;
               end
            end
            default: begin
               state_q       <= IDLE;
               res_valid_q   <= 1'b0;
               start_ready_q <= 1'b1;
               busy_q        <= 1'b0;
            end
         endcase
      end
   end

   assign start_ready = start_ready_q;
   assign res_valid   = res_valid_q;
   assign quotient    = quotient_q;
   assign remainder   = remainder_q;
   assign div_by_zero = dbz_q;
   assign busy        = busy_q;

endmodule

// File: doc/div_ctrl.md
DIV_CTRL -- requirements
Module: div_ctrl

Interface
REQ-001 Parameters: none; operand width is fixed at 16 through the package constant DIV_W.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-004 start_valid  input  1  requester presents an operand pair.
REQ-005 start_ready  output  1  controller can accept an operand pair.
REQ-006 dividend  input  16  unsigned dividend, sampled on start handshake.
REQ-007 divisor  input  16  unsigned divisor, sampled on start handshake.
REQ-008 res_valid  output  1  quotient, remainder and div_by_zero are valid.
REQ-009 res_ready  input  1  consumer accepts the result.
REQ-010 quotient  output  16  unsigned quotient, registered.
REQ-011 remainder  output  16  unsigned remainder, registered.
REQ-012 div_by_zero  output  1  the sampled divisor was 0, registered.
REQ-013 busy  output  1  high whenever state != IDLE.

Function
REQ-014 The FSM SHALL have three states: IDLE, RUN and DONE (encoding enum div_state_t).
REQ-015 start_ready SHALL equal (state == IDLE); no other input gates it.
REQ-016 When start_valid && start_ready, the block SHALL register dividend and divisor, clear the partial remainder R (17 bits) and quotient, set iteration counter cnt=0, and enter RUN.
REQ-017 Each RUN cycle SHALL perform one restoring step MSB-first:
- Rs = {R[15:0], dividend_reg[15-cnt]}.
- If Rs >= {1'b0, divisor_reg}: R <= {1'b0, sub(Rs[15:0], divisor_reg)} and quotient bit 15-cnt = 1.
- Else R <= Rs and quotient bit = 0.
REQ-018 The 16-bit subtraction in REQ-017 SHALL be unsigned modulo 2^16. The compare SHALL be 17-bit unsigned. The result fits in 16 bits because Rs < 2*divisor.
REQ-019 cnt SHALL be 4 bits. After the step with cnt==15, the FSM SHALL enter DONE; cnt does not wrap into a 17th step.
REQ-020 Latency: res_valid SHALL rise exactly 16 clock edges after the accepting edge for non-zero divisors.
REQ-021 In DONE, res_valid=1. quotient, remainder and div_by_zero SHALL be stable until res_valid && res_ready.
REQ-022 On res_valid && res_ready, the FSM SHALL return to IDLE. start_ready is high the following cycle; no same-cycle start acceptance occurs in DONE.
REQ-023 In IDLE and RUN, res_valid SHALL be 0. quotient and remainder outputs SHALL hold their last values and update only on entry to DONE.
REQ-024 div_by_zero SHALL be set to (divisor == 0) on acceptance and cleared on the next acceptance.
REQ-025 With divisor 0, the result SHALL be quotient=0xFFFF and remainder=dividend in all configurations.
REQ-026 Start_valid while busy SHALL be ignored and the request SHALL not be captured. res_ready outside DONE SHALL be ignored.

Reset
REQ-027 Asserting rst_n low SHALL immediately force state=IDLE, cnt=0, R=0, quotient=0, remainder=0, div_by_zero=0, res_valid=0, busy=0, and start_ready=1 (after release).
REQ-028 Reset during RUN or DONE SHALL abort the operation with no residual result. The first start after release behaves normally.

Configuration
REQ-029 Macro DIV_ZERO_FAST_EN: when defined, an accepted divisor of 0 SHALL go IDLE->DONE directly, so res_valid rises 1 edge after acceptance with the REQ-025 values.
REQ-030 When DIV_ZERO_FAST_EN is undefined, divisor 0 SHALL run all 16 RUN steps (latency 16) and produce the same values naturally.

Structure
REQ-031 Package div_pkg SHALL hold DIV_W=16, DIV_ITER=16 and div_state_t.
REQ-032 The datapath subtraction SHALL use one instance of the existing 16-bit sub module (rs1=Rs[15:0], rs2=divisor_reg, rd). No other sub-modules are used.

Verification
REQ-033 dividend=100, divisor=7, res_ready=1 -> quotient=14, remainder=2, div_by_zero=0, res_valid 16 edges after accept.
REQ-034 dividend=0xFFFF, divisor=1 -> quotient=0xFFFF, remainder=0. Then dividend=5, divisor=0xFFFF -> quotient=0, remainder=5.
REQ-035 dividend=0x1234, divisor=0 -> quotient=0xFFFF, remainder=0x1234, div_by_zero=1. Latency is 1 with DIV_ZERO_FAST_EN and 16 without.
REQ-036 Hold res_ready=0 for 5 cycles in DONE -> outputs stable, start_ready=0. A start_valid pulse during this window is not captured. Raise res_ready -> IDLE next edge.
REQ-037 Assert rst_n low at RUN cnt=7 -> all outputs zero immediately. After release, 9/3 -> quotient=3, remainder=0.
REQ-038 Random back-to-back operand pairs (1000) SHALL be checked against a reference model: quotient==a/b and remainder==a%b (b!=0).
